// File: rtl/seven_seg_scanner_if.sv
// seven_seg_scanner_if
//   Bundles the scanner's display-side and mux-side signals.
//   enable      : 1 = scan, 0 = display dark and scanner parked
//   nibble      : hex value returned by the upstream half_byte_mux for digit_sel
//   dp_mask     : dp_mask[i] = 1 lights the decimal point of digit i
//   digit_sel   : registered digit index fed to the half_byte_mux byte_select
//   anode_n     : active-low one-hot anode drive
//   seg_n       : active-low segments {g,f,e,d,c,b,a}
//   dp_n        : active-low decimal point
//   frame_tick  : one-cycle pulse after digit_sel wraps 7 -> 0
// Modports: master = scanner side, slave = controller/display side.
interface seven_seg_scanner_if;
    logic       enable;
    logic [3:0] nibble;
    logic [7:0] dp_mask;
    logic [2:0] digit_sel;
    logic [7:0] anode_n;
    logic [6:0] seg_n;
    logic       dp_n;
    logic       frame_tick;

    modport master (
        input  enable, nibble, dp_mask,
        output digit_sel, anode_n, seg_n, dp_n, frame_tick
    );

    modport slave (
        output enable, nibble, dp_mask,
        input  digit_sel, anode_n, seg_n, dp_n, frame_tick
    );
endinterface

// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner
//   Time-multiplexed driver for an 8-digit common-anode seven-segment display.
//   Each digit slot is BLANK_CYCLES clocks with all anodes off followed by
//   DWELL_CYCLES-BLANK_CYCLES clocks with the digit lit. Digit 0 is the most
//   significant nibble. All outputs are registered.
// Ports
//   clk   : single clock, rising edge
//   rstb  : asynchronous active-low reset
//   bus   : seven_seg_scanner_if.master (enable, nibble, dp_mask in;
//           digit_sel, anode_n, seg_n, dp_n, frame_tick out)
// Configuration
//   LEADING_ZERO_BLANK_EN : when defined, leading zero digits 0..6 are blanked.
module seven_seg_scanner #(
    parameter int unsigned DWELL_CYCLES = 50000,
    parameter int unsigned BLANK_CYCLES = 1000
) (
    input logic                  clk,
    input logic                  rstb,
    seven_seg_scanner_if.master  bus
);

    localparam int unsigned CntW = (DWELL_CYCLES > 2) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [CntW-1:0] BlankLast = CntW'(BLANK_CYCLES - 1);
    localparam logic [CntW-1:0] DwellLast = CntW'(DWELL_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StBlank, StShow} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      sel_q, sel_d;
    logic [7:0]      anode_q, anode_d;
    logic [6:0]      seg_q, seg_d;
    logic            dp_q, dp_d;
    logic            tick_q, tick_d;
`ifdef LEADING_ZERO_BLANK_EN
    logic            nz_seen_q, nz_seen_d;
    logic            nz_eff;
`endif

    function automatic logic [6:0] decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        anode_d = anode_q;
        seg_d   = seg_q;
        dp_d    = dp_q;
        tick_d  = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        nz_seen_d = nz_seen_q;
        // Digit 0 starts a new number, so forget earlier non-zero digits.
        nz_eff    = (sel_q == 3'd0) ? 1'b0 : nz_seen_q;
`endif

        if (!bus.enable) begin
            // Abandon any partial slot; restart at digit 0 on re-enable.
            state_d = StIdle;
            cnt_d   = '0;
            sel_d   = 3'd0;
            anode_d = 8'hFF;
            seg_d   = 7'h7F;
            dp_d    = 1'b1;
        end else begin
            case (state_q)
                StIdle: begin
                    state_d = StBlank;
                    cnt_d   = '0;
                end
                StBlank: begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == BlankLast) begin
                        // Mux output has settled for a full blank period by now.
                        state_d = StShow;
                        anode_d = ~(8'b1 << sel_q);
                        dp_d    = ~bus.dp_mask[sel_q];
`ifdef LEADING_ZERO_BLANK_EN
                        if (bus.nibble == 4'h0 && !nz_eff && sel_q != 3'd7) begin
                            seg_d     = 7'h7F;
                            nz_seen_d = 1'b0;
                        end else begin
                            seg_d     = decode(bus.nibble);
                            nz_seen_d = 1'b1;
                        end
`else
                        seg_d   = decode(bus.nibble);
`endif
                    end
                end
                StShow: begin
                    if (cnt_q == DwellLast) begin
                        state_d = StBlank;
                        cnt_d   = '0;
                        sel_d   = sel_q + 3'd1;
                        anode_d = 8'hFF;
                        tick_d  = (sel_q == 3'd7);
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            sel_q     <= 3'd0;
            anode_q   <= 8'hFF;
            seg_q     <= 7'h7F;
            dp_q      <= 1'b1;
            tick_q    <= 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
            nz_seen_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sel_q     <= sel_d;
            anode_q   <= anode_d;
            seg_q     <= seg_d;
            dp_q      <= dp_d;
            tick_q    <= tick_d;
`ifdef LEADING_ZERO_BLANK_EN
            nz_seen_q <= nz_seen_d;
`endif
        end
    end

    assign bus.digit_sel  = sel_q;
    assign bus.anode_n    = anode_q;
    assign bus.seg_n      = seg_q;
    assign bus.dp_n       = dp_q;
    assign bus.frame_tick = tick_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// tb_seven_seg_scanner
//   Directed bench for seven_seg_scanner with DWELL_CYCLES=8, BLANK_CYCLES=2.
//   A behavioural half_byte_mux returns x's nibble for the current digit_sel.
//   Expected per-slot segment/dp values are queued when stimulus is set up and
//   popped when the DUT enters the SHOW part of each slot.
module tb_seven_seg_scanner;

    localparam int unsigned Dwell = 8;
    localparam int unsigned Blank = 2;

    typedef struct packed {
        logic [2:0] dig;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    logic        clk;
    logic        rstb;
    logic [31:0] x;
    exp_t        sb[$];
    int          n_cmp;
    int          n_fail;
    bit          model_nz;
    int          ft_total;

    seven_seg_scanner_if bus ();

    seven_seg_scanner #(
        .DWELL_CYCLES (Dwell),
        .BLANK_CYCLES (Blank)
    ) dut (
        .clk  (clk),
        .rstb (rstb),
        .bus  (bus)
    );

    // Behavioural half_byte_mux: digit 0 is x[31:28].
    always_comb begin
        logic [31:0] sh;
        sh = x >> ({2'b00, ~bus.digit_sel} * 3'd4);
        bus.nibble = sh[3:0];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] seg_of(input logic [3:0] v);
        case (v)
            4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    // Queue the expected SHOW content for n slots starting at digit 0.
    task automatic push_slots(input int n);
        for (int s = 0; s < n; s++) begin
            exp_t       e;
            logic [2:0] d;
            logic [3:0] nib;
            d   = 3'(s % 8);
            nib = 4'((x >> (4 * (7 - int'(d)))) & 32'hF);
            if (d == 3'd0) model_nz = 1'b0;
            e.dig = d;
            e.dp  = ~dp_mask_bit(d);
`ifdef LEADING_ZERO_BLANK_EN
            if (nib == 4'h0 && !model_nz && d != 3'd7) begin
                e.seg = 7'h7F;
            end else begin
                e.seg    = seg_of(nib);
                model_nz = 1'b1;
            end
`else
            e.seg = seg_of(nib);
`endif
            sb.push_back(e);
        end
    endtask

    function automatic logic dp_mask_bit(input logic [2:0] d);
        logic [7:0] m;
        m = bus.dp_mask;
        return m[d];
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Run n full slots from a fresh start at digit 0, sampling every cycle.
    task automatic scan_slots(input int n);
        ft_total = 0;
        for (int s = 0; s < n; s++) begin
            logic [2:0] d;
            logic [7:0] an_exp;
            logic [6:0] seg_ref;
            logic       dp_ref;
            int         lowcnt, blank_bad, sel_bad, ft_bad, hold_bad;
            d = 3'(s % 8);
            an_exp = ~(8'b1 << d);
            lowcnt = 0; blank_bad = 0; sel_bad = 0; ft_bad = 0; hold_bad = 0;
            seg_ref = 7'h7F; dp_ref = 1'b1;
            for (int c = 0; c < int'(Dwell); c++) begin
                step();
                if (bus.digit_sel !== d) sel_bad++;
                if (c < int'(Blank) && bus.anode_n !== 8'hFF) blank_bad++;
                if (bus.anode_n === an_exp) lowcnt++;
                if (bus.frame_tick === 1'b1) ft_total++;
                if (bus.frame_tick !== ((c == 0 && d == 3'd0 && s > 0) ? 1'b1 : 1'b0)) ft_bad++;
                if (c == int'(Blank)) begin
                    seg_ref = bus.seg_n;
                    dp_ref  = bus.dp_n;
                    if (sb.size() == 0) begin
                        check("scoreboard_empty", 32'd1, 32'd0);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        check($sformatf("slot%0d_digit", s), 32'(d), 32'(e.dig));
                        check($sformatf("slot%0d_seg_n", s), 32'(bus.seg_n), 32'(e.seg));
                        check($sformatf("slot%0d_dp_n", s), 32'(bus.dp_n), 32'(e.dp));
                    end
                end else if (c > int'(Blank)) begin
                    if (bus.seg_n !== seg_ref || bus.dp_n !== dp_ref) hold_bad++;
                end
            end
            check($sformatf("slot%0d_sel_held", s), 32'(sel_bad), 32'd0);
            check($sformatf("slot%0d_blank_dark", s), 32'(blank_bad), 32'd0);
            check($sformatf("slot%0d_anode_low_cnt", s), 32'(lowcnt), 32'(Dwell - Blank));
            check($sformatf("slot%0d_frame_tick", s), 32'(ft_bad), 32'd0);
            check($sformatf("slot%0d_seg_hold", s), 32'(hold_bad), 32'd0);
        end
    endtask

    task automatic check_dark(input string tag);
        check({tag, "_anode_n"}, 32'(bus.anode_n), 32'hFF);
        check({tag, "_seg_n"}, 32'(bus.seg_n), 32'h7F);
        check({tag, "_dp_n"}, 32'(bus.dp_n), 32'd1);
        check({tag, "_digit_sel"}, 32'(bus.digit_sel), 32'd0);
        check({tag, "_frame_tick"}, 32'(bus.frame_tick), 32'd0);
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        model_nz = 1'b0;
        rstb = 1'b1;
        bus.enable = 1'b0;
        bus.dp_mask = 8'h00;
        x = 32'h0123ABCF;
        #2 rstb = 1'b0;

        // Reset state
        @(negedge clk);
        check_dark("reset");

        // Release with enable high; two frames plus one slot covers scan and wrap
        rstb = 1'b1;
        bus.enable = 1'b1;
        push_slots(17);
        scan_slots(17);
        check("frame_tick_count", 32'(ft_total), 32'd2);

        // Asynchronous reset in the middle of digit 1's SHOW
        for (int i = 0; i < 4; i++) step();
        check("pre_reset_anode", 32'(bus.anode_n), 32'hFD);
        #2 rstb = 1'b0;
        #1 check_dark("async_reset");
        @(negedge clk);
        rstb = 1'b1;
        push_slots(5);
        scan_slots(5);

        // Disable while digit 5 is shown
        for (int i = 0; i < 3; i++) step();
        check("dig5_sel", 32'(bus.digit_sel), 32'd5);
        check("dig5_anode", 32'(bus.anode_n), 32'hDF);
        bus.enable = 1'b0;
        step();
        check_dark("disable");
        for (int i = 0; i < 3; i++) step();
        check_dark("idle_hold");

        // Re-enable with one decimal point on digit 2
        bus.dp_mask = 8'h04;
        bus.enable = 1'b1;
        push_slots(8);
        scan_slots(8);

        // Leading-zero pattern
        bus.enable = 1'b0;
        step();
        x = 32'h000000A0;
        bus.dp_mask = 8'h00;
        step();
        bus.enable = 1'b1;
        push_slots(8);
        scan_slots(8);

        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
